// File: rtl/xbar_pkg.sv
// Shared defaults, accumulator width rule and sequencer state encoding
// for the crossbar dot-product datapath.
package xbar_pkg;

  localparam int unsigned IN_W_DEF    = 4;
  localparam int unsigned W_W_DEF     = 4;
  localparam int unsigned N_TERMS_DEF = 4;

  // Width that holds N_TERMS full-scale products without wrapping.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned w_w,
                                            input int unsigned n_terms);
    return in_w + w_w + $clog2(n_terms);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/xbar_bitserial_mul.sv
// Bit-serial shift-add multiplier: latches one operand pair, then emits one
// shifted partial product per cycle for IN_W cycles plus a done pulse.
module xbar_bitserial_mul #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned W_W   = 4,
  parameter int unsigned ACC_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  in_op,
  input  logic [W_W-1:0]   w_op,
  output logic             busy,
  output logic [ACC_W-1:0] pp,
  output logic             done
);

  localparam int unsigned BC_W = (IN_W > 1) ? $clog2(IN_W) : 1;

  logic [IN_W-1:0] in_q, in_d;
  logic [W_W-1:0]  w_q, w_d;
  logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
  logic            busy_q, busy_d;
  logic            last_bit;

  assign last_bit = (bit_cnt_q == BC_W'(IN_W - 1));

  always_comb begin
    in_d      = in_q;
    w_d       = w_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    if (start) begin
      in_d      = in_op;
      w_d       = w_op;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (last_bit) begin
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      w_q       <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      in_q      <= in_d;
      w_q       <= w_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Zero operand bits still occupy their cycle; only the addend is gated.
  assign pp   = (busy_q && in_q[bit_cnt_q]) ? (ACC_W'(w_q) << bit_cnt_q) : '0;
  assign done = busy_q && last_bit;
  assign busy = busy_q;

endmodule

// File: rtl/xbar_dot_sequencer.sv
// Feeds (activation, weight) pairs through the bit-serial multiplier,
// accumulates the dot product and offers one sum per vector on a valid/ready port.
module xbar_dot_sequencer
  import xbar_pkg::*;
#(
  parameter  int unsigned N_TERMS = N_TERMS_DEF,
  parameter  int unsigned IN_W    = IN_W_DEF,
  parameter  int unsigned W_W     = W_W_DEF,
  localparam int unsigned ACC_W   = acc_width(IN_W, W_W, N_TERMS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_in,
  input  logic [W_W-1:0]   s_weight,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_sum,
  output logic             m_frame_err
);

  localparam int unsigned TC_W = $clog2(N_TERMS + 1);

  seq_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [TC_W-1:0]  term_cnt_q, term_cnt_d;
  logic [TC_W-1:0]  term_next;
  logic             last_q, last_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [ACC_W-1:0] m_sum_q, m_sum_d;
  logic             m_frame_err_q, m_frame_err_d;
  logic             full;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [ACC_W-1:0] mul_pp;

  xbar_bitserial_mul #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mul (
    .clk   (clock),
    .rst_n (reset_n),
    .start (mul_start),
    .in_op (s_in),
    .w_op  (s_weight),
    .busy  (mul_busy),
    .pp    (mul_pp),
    .done  (mul_done)
  );

  assign term_next = term_cnt_q + 1'b1;
  assign full      = (term_next == TC_W'(N_TERMS));

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    term_cnt_d    = term_cnt_q;
    last_d        = last_q;
    s_ready_d     = s_ready_q;
    m_valid_d     = m_valid_q;
    m_sum_d       = m_sum_q;
    m_frame_err_d = m_frame_err_q;
    mul_start     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_valid) begin
          mul_start = 1'b1;
          last_d    = s_last;
          s_ready_d = 1'b0;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (mul_busy) acc_d = acc_q + mul_pp;
        if (mul_done) begin
          term_cnt_d = term_next;
          if (last_q || full) begin
            // Error exactly when the s_last marker disagrees with the term count.
            m_valid_d     = 1'b1;
            m_sum_d       = acc_d;
            m_frame_err_d = last_q ^ full;
            state_d       = DONE;
          end else begin
            s_ready_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DONE: begin
        if (m_ready) begin
          acc_d      = '0;
          term_cnt_d = '0;
          m_valid_d  = 1'b0;
          s_ready_d  = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      term_cnt_q    <= '0;
      last_q        <= 1'b0;
      s_ready_q     <= 1'b1;
      m_valid_q     <= 1'b0;
      m_sum_q       <= '0;
      m_frame_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      term_cnt_q    <= term_cnt_d;
      last_q        <= last_d;
      s_ready_q     <= s_ready_d;
      m_valid_q     <= m_valid_d;
      m_sum_q       <= m_sum_d;
      m_frame_err_q <= m_frame_err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_sum       = m_sum_q;
  assign m_frame_err = m_frame_err_q;

endmodule

// File: tb/tb_xbar_dot_sequencer.sv
// Directed and randomised checks of the dot-product sequencer against
// hand-computed sums and a reference dot-product model.
module tb_xbar_dot_sequencer;

  localparam int unsigned N_TERMS = 4;
  localparam int unsigned IN_W    = 4;
  localparam int unsigned W_W     = 4;
  localparam int unsigned ACC_W   = 10;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [IN_W-1:0]  s_in = '0;
  logic [W_W-1:0]   s_weight = '0;
  logic             s_last = 1'b0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [ACC_W-1:0] m_sum;
  logic             m_frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  xbar_dot_sequencer #(
    .N_TERMS (N_TERMS),
    .IN_W    (IN_W),
    .W_W     (W_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_in        (s_in),
    .s_weight    (s_weight),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_sum       (m_sum),
    .m_frame_err (m_frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Called and returns on a falling edge; handshake lands on the rising edge between.
  task automatic send(input int a, input int w, input bit l, input bit scramble);
    int n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("s_ready_timeout", 32'd0, 32'd1);
    s_valid  = 1'b1;
    s_in     = IN_W'(a);
    s_weight = W_W'(w);
    s_last   = l;
    @(posedge clock);
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (scramble) begin
      for (int i = 0; i < int'(IN_W) + 2; i++) begin
        s_in     = IN_W'($urandom);
        s_weight = W_W'($urandom);
        s_last   = 1'($urandom);
        @(negedge clock);
      end
      s_last = 1'b0;
    end
  endtask

  task automatic get_result(input string tag, input int exp_sum, input int exp_err, input int hold);
    int n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    check({tag, "_sum"}, 32'(m_sum), 32'(exp_sum));
    check({tag, "_err"}, 32'(m_frame_err), 32'(exp_err));
    repeat (hold) @(negedge clock);
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int exp_sum;
    int nt;
    bit last4;
    int a, w;

    repeat (2) @(negedge clock);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_sum", 32'(m_sum), 32'd0);
    check("rst_m_frame_err", 32'(m_frame_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // T1: reset while a sum is pending, then reset mid-MUL
    send(2, 3, 0, 0); send(2, 3, 0, 0); send(2, 3, 0, 0); send(2, 3, 1, 0);
    lat = 0;
    while (!m_valid && lat < 50) begin @(negedge clock); lat++; end
    check("t1_pending_sum", 32'(m_sum), 32'd24);
    reset_n = 1'b0;
    #1;
    check("t1_done_rst_m_valid", 32'(m_valid), 32'd0);
    check("t1_done_rst_m_sum", 32'(m_sum), 32'd0);
    check("t1_done_rst_s_ready", 32'(s_ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(15, 15, 0, 0);
    @(negedge clock);
    check("t1_mul_s_ready_low", 32'(s_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t1_mul_rst_s_ready", 32'(s_ready), 32'd1);
    check("t1_mul_rst_m_valid", 32'(m_valid), 32'd0);
    check("t1_mul_rst_m_sum", 32'(m_sum), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send(1, 1, 1, 0);
    get_result("t1_after", 1, 1, 0);

    // T2: 77+1+0+0, latency IN_W cycles after the closing accept
    send(11, 7, 0, 0); send(1, 1, 0, 0); send(0, 15, 0, 0); send(15, 0, 1, 0);
    lat = 0;
    while (!m_valid && lat < 50) begin @(negedge clock); lat++; end
    check("t2_latency", 32'(lat), 32'(IN_W));
    get_result("t2", 78, 0, 0);
    check("t2_s_ready_after", 32'(s_ready), 32'd1);

    // T3: full-scale operands
    for (int i = 0; i < 4; i++) send(15, 15, (i == 3), 0);
    get_result("t3", 900, 0, 0);

    // T4: early s_last, then overlong vector split at N_TERMS
    send(3, 5, 0, 0); send(2, 2, 1, 0);
    get_result("t4_short", 19, 1, 0);
    send(1, 1, 0, 0); send(2, 2, 0, 0); send(3, 3, 0, 0); send(4, 4, 0, 0);
    get_result("t4_long", 30, 1, 0);
    send(5, 5, 0, 0); send(1, 2, 1, 0);
    get_result("t4_next", 27, 1, 0);

    // T5: backpressure holds the sum and blocks input
    for (int i = 0; i < 4; i++) send(1, 2, (i == 3), 0);
    lat = 0;
    while (!m_valid && lat < 50) begin @(negedge clock); lat++; end
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_in     = IN_W'($urandom);
      s_weight = W_W'($urandom);
      s_last   = 1'($urandom);
      @(negedge clock);
      check("t5_hold_sum", 32'(m_sum), 32'd8);
      check("t5_hold_s_ready", 32'(s_ready), 32'd0);
      check("t5_hold_m_valid", 32'(m_valid), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    @(negedge clock);
    check("t5_release_m_valid", 32'(m_valid), 32'd0);
    check("t5_release_s_ready", 32'(s_ready), 32'd1);
    repeat (3) @(negedge clock);
    check("t5_idle_ready_no_effect", 32'(m_valid), 32'd0);
    m_ready = 1'b0;
    send(3, 3, 1, 0);
    get_result("t5_next", 9, 1, 0);

    // T6: inputs churn during MUL
    send(9, 6, 0, 1); send(7, 13, 0, 1); send(12, 3, 0, 1); send(5, 10, 1, 1);
    get_result("t6", 54 + 91 + 36 + 50, 0, 2);

    // Random vectors against a reference dot product
    for (int v = 0; v < 1000; v++) begin
      nt      = $urandom_range(1, 4);
      last4   = 1'($urandom);
      exp_sum = 0;
      for (int t = 1; t <= nt; t++) begin
        a = $urandom_range(0, 15);
        w = $urandom_range(0, 15);
        exp_sum += a * w;
        send(a, w, (t < 4) ? (t == nt) : last4, 1'($urandom));
      end
      get_result("rand", exp_sum, (nt < 4) ? 1 : int'(!last4), $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
